// File: rtl/usb_fifo_responder_if.sv
// usb_fifo_responder_if: host-side command/capture handshake and status between user logic and the responder
interface usb_fifo_responder_if #(
  parameter int DEPTH_CAP = 256
) ();
  logic [15:0] host_cmd_data;
  logic host_cmd_valid;
  logic host_cmd_ready;
  logic [15:0] cap_data;
  logic cap_valid;
  logic cap_ready;
  logic [$clog2(DEPTH_CAP):0] cap_count;
  logic burst_done;
  logic [8:0] burst_len;
  logic overflow;
  logic proto_err;
  modport master (
    output host_cmd_data, host_cmd_valid, cap_ready,
    input  host_cmd_ready, cap_data, cap_valid, cap_count, burst_done, burst_len, overflow, proto_err
  );
  modport slave (
    input  host_cmd_data, host_cmd_valid, cap_ready,
    output host_cmd_ready, cap_data, cap_valid, cap_count, burst_done, burst_len, overflow, proto_err
  );
endinterface

// File: rtl/usb_fifo_responder.sv
// usb_fifo_responder: device side of a 16-bit FT600-style FIFO bus with command and capture FIFOs
module usb_fifo_responder #(
  parameter int DEPTH_CMD = 16,
  parameter int DEPTH_CAP = 256
) (
  input  logic clk,
  input  logic reset,
  usb_fifo_responder_if.slave h,
  output logic RXF_N,
  output logic TXE_N,
  input  logic OE_N,
  input  logic RD_N,
  input  logic WR_N,
  inout  wire [15:0] DATA,
  inout  wire [1:0] BE
);
  localparam int CW = $clog2(DEPTH_CMD);
  localparam int PW = $clog2(DEPTH_CAP);
  localparam logic [CW:0] CMD_FULL = (CW + 1)'(DEPTH_CMD);
  localparam logic [PW:0] CAP_FULL = (PW + 1)'(DEPTH_CAP);
  typedef enum logic [1:0] {BUS_IDLE, BUS_READ, BUS_WRITE} bus_e;
  bus_e state_q, state_d;
  logic [15:0] cmd_mem [DEPTH_CMD];
  logic [15:0] cap_mem [DEPTH_CAP];
  logic [CW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CW:0] cmd_cnt_q, cmd_cnt_d;
  logic [PW-1:0] cap_wp_q, cap_wp_d, cap_rp_q, cap_rp_d;
  logic [PW:0] cap_cnt_q, cap_cnt_d;
  logic [8:0] burst_cnt_q, burst_cnt_d, burst_len_q, burst_len_d, burst_inc;
  logic burst_done_q, burst_done_d, overflow_q, overflow_d, proto_err_q, proto_err_d;
  logic cmd_push, cmd_pop, cap_push, cap_pop, wr_ok;
  logic [15:0] cmd_head;
  assign cmd_head = cmd_cnt_q != '0 ? cmd_mem[cmd_rp_q] : 16'h0000;
  assign DATA = !OE_N ? cmd_head : 16'hzzzz;
  assign BE = !OE_N ? 2'b11 : 2'bzz;
  assign RXF_N = cmd_cnt_q == '0;
  assign TXE_N = cap_cnt_q == CAP_FULL;
  assign h.host_cmd_ready = cmd_cnt_q != CMD_FULL;
  assign h.cap_valid = cap_cnt_q != '0;
  assign h.cap_data = cap_cnt_q != '0 ? cap_mem[cap_rp_q] : 16'h0000;
  assign h.cap_count = cap_cnt_q;
  assign h.burst_done = burst_done_q;
  assign h.burst_len = burst_len_q;
  assign h.overflow = overflow_q;
  assign h.proto_err = proto_err_q;
  always_comb begin
    cmd_push = h.host_cmd_valid && cmd_cnt_q != CMD_FULL;
    cmd_pop = !OE_N && !RD_N && cmd_cnt_q != '0;
    wr_ok = !WR_N && OE_N;
    cap_push = wr_ok && cap_cnt_q != CAP_FULL;
    cap_pop = h.cap_ready && cap_cnt_q != '0;
    cmd_wp_d = cmd_push ? cmd_wp_q + 1'b1 : cmd_wp_q;
    cmd_rp_d = cmd_pop ? cmd_rp_q + 1'b1 : cmd_rp_q;
    cmd_cnt_d = cmd_cnt_q + {{CW{1'b0}}, cmd_push} - {{CW{1'b0}}, cmd_pop};
    cap_wp_d = cap_push ? cap_wp_q + 1'b1 : cap_wp_q;
    cap_rp_d = cap_pop ? cap_rp_q + 1'b1 : cap_rp_q;
    cap_cnt_d = cap_cnt_q + {{PW{1'b0}}, cap_push} - {{PW{1'b0}}, cap_pop};
    overflow_d = overflow_q || (wr_ok && !cap_push);
    proto_err_d = proto_err_q || (!WR_N && !OE_N);
    burst_inc = burst_cnt_q == 9'd511 ? burst_cnt_q : burst_cnt_q + 9'd1;
    burst_cnt_d = cap_push ? burst_inc : burst_cnt_q;
    burst_len_d = burst_len_q;
    burst_done_d = 1'b0;
    state_d = state_q;
    case (state_q)
      BUS_IDLE: begin
        state_d = !OE_N ? BUS_READ : !WR_N ? BUS_WRITE : BUS_IDLE;
        // The opening edge of a burst already carries its first word
        if (OE_N && !WR_N) burst_cnt_d = {8'd0, cap_push};
      end
      BUS_READ: state_d = OE_N ? BUS_IDLE : BUS_READ;
      BUS_WRITE: begin
        state_d = WR_N ? BUS_IDLE : BUS_WRITE;
        burst_done_d = WR_N;
        burst_len_d = WR_N ? burst_cnt_q : burst_len_q;
      end
      default: state_d = BUS_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp_q] <= h.host_cmd_data;
    if (cap_push) cap_mem[cap_wp_q] <= DATA;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      cmd_wp_q <= '0;
      cmd_rp_q <= '0;
      cmd_cnt_q <= '0;
      cap_wp_q <= '0;
      cap_rp_q <= '0;
      cap_cnt_q <= '0;
      burst_cnt_q <= '0;
      burst_len_q <= '0;
      burst_done_q <= 1'b0;
      overflow_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_wp_q <= cmd_wp_d;
      cmd_rp_q <= cmd_rp_d;
      cmd_cnt_q <= cmd_cnt_d;
      cap_wp_q <= cap_wp_d;
      cap_rp_q <= cap_rp_d;
      cap_cnt_q <= cap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      burst_len_q <= burst_len_d;
      burst_done_q <= burst_done_d;
      overflow_q <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_usb_fifo_responder.sv
// tb_usb_fifo_responder: vector table, hand-written corner sequences and a queue-based random reference check
module tb_usb_fifo_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic hv = 1'b0, cr = 1'b0, oe_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [15:0] hd = '0, wd = '0;
  wire [15:0] DATA;
  wire [1:0] BE;
  logic RXF_N, TXE_N;
  int n_tests = 0, n_fail = 0;
  usb_fifo_responder_if ifc ();
  assign ifc.host_cmd_data = hd;
  assign ifc.host_cmd_valid = hv;
  assign ifc.cap_ready = cr;
  assign DATA = (!wr_n && oe_n) ? wd : 16'hzzzz;
  assign BE = (!wr_n && oe_n) ? 2'b11 : 2'bzz;
  usb_fifo_responder dut (
    .clk(clk), .reset(rst), .h(ifc), .RXF_N(RXF_N), .TXE_N(TXE_N),
    .OE_N(oe_n), .RD_N(rd_n), .WR_N(wr_n), .DATA(DATA), .BE(BE)
  );
  typedef struct {
    logic hv; logic [15:0] hd; logic oe_n, rd_n, wr_n; logic [15:0] wd; logic cr;
    logic e_rdy, e_rxf, e_txe; logic [15:0] e_data; logic [8:0] e_cnt; logic [15:0] e_cap;
    logic e_done; logic [8:0] e_len; logic e_perr;
  } vec_t;
  vec_t v [14];
  // Reference model: plain queues and the bus rules stated as booleans
  logic [15:0] mcmd [$];
  logic [15:0] mcap [$];
  bit m_rd, m_wr, movf, mperr, mdone;
  int blen, mlen;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    mcmd.delete();
    mcap.delete();
    m_rd = 0; m_wr = 0; movf = 0; mperr = 0; mdone = 0; blen = 0; mlen = 0;
  endtask
  task automatic model_step();
    bit push_h, pop_b, wr, acc, pop_c;
    push_h = hv && mcmd.size() < 16;
    pop_b = !oe_n && !rd_n && mcmd.size() > 0;
    wr = !wr_n && oe_n;
    acc = wr && mcap.size() < 256;
    pop_c = cr && mcap.size() > 0;
    if (pop_b) void'(mcmd.pop_front());
    if (push_h) mcmd.push_back(hd);
    if (pop_c) void'(mcap.pop_front());
    if (acc) mcap.push_back(wd);
    if (wr && !acc) movf = 1;
    if (!wr_n && !oe_n) mperr = 1;
    if (acc) blen = blen == 511 ? 511 : blen + 1;
    mdone = 0;
    if (!m_rd && !m_wr) begin
      if (!oe_n) m_rd = 1;
      else if (!wr_n) begin m_wr = 1; blen = acc ? 1 : 0; end
    end else if (m_rd) begin
      if (oe_n) m_rd = 0;
    end else if (wr_n) begin
      m_wr = 0; mdone = 1; mlen = blen;
    end
  endtask
  task automatic check_all(input int cyc);
    string t;
    t = $sformatf("rnd%0d", cyc);
    chk({t, " ready"}, ifc.host_cmd_ready, mcmd.size() < 16);
    chk({t, " rxf_n"}, RXF_N, mcmd.size() == 0);
    chk({t, " txe_n"}, TXE_N, mcap.size() == 256);
    chk({t, " cap_valid"}, ifc.cap_valid, mcap.size() > 0);
    chk({t, " cap_data"}, ifc.cap_data, mcap.size() > 0 ? mcap[0] : 16'h0);
    chk({t, " cap_count"}, ifc.cap_count, mcap.size());
    chk({t, " done"}, ifc.burst_done, mdone);
    chk({t, " len"}, ifc.burst_len, mlen);
    chk({t, " ovf"}, ifc.overflow, movf);
    chk({t, " perr"}, ifc.proto_err, mperr);
    if (!oe_n) begin
      chk({t, " data"}, DATA, mcmd.size() > 0 ? mcmd[0] : 16'h0);
      chk({t, " be"}, BE, 2'b11);
    end
  endtask
  task automatic idle_inputs();
    hv = 0; cr = 0; oe_n = 1; rd_n = 1; wr_n = 1; hd = 0; wd = 0;
  endtask
  task automatic check_reset_values(input string t);
    chk({t, " ready"}, ifc.host_cmd_ready, 1);
    chk({t, " rxf_n"}, RXF_N, 1);
    chk({t, " txe_n"}, TXE_N, 0);
    chk({t, " cap_valid"}, ifc.cap_valid, 0);
    chk({t, " cap_data"}, ifc.cap_data, 0);
    chk({t, " cap_count"}, ifc.cap_count, 0);
    chk({t, " done"}, ifc.burst_done, 0);
    chk({t, " len"}, ifc.burst_len, 0);
    chk({t, " ovf"}, ifc.overflow, 0);
    chk({t, " perr"}, ifc.proto_err, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int dones, n;
    logic [15:0] first, last;
    v[0]  = '{1, 16'hA5A5, 1, 1, 1, 16'h0,    0, 1, 0, 0, 16'h0,    9'd0, 16'h0,    0, 9'd0, 0};
    v[1]  = '{1, 16'h0001, 1, 1, 1, 16'h0,    0, 1, 0, 0, 16'h0,    9'd0, 16'h0,    0, 9'd0, 0};
    v[2]  = '{0, 16'h0,    0, 1, 1, 16'h0,    0, 1, 0, 0, 16'hA5A5, 9'd0, 16'h0,    0, 9'd0, 0};
    v[3]  = '{0, 16'h0,    0, 0, 1, 16'h0,    0, 1, 0, 0, 16'h0001, 9'd0, 16'h0,    0, 9'd0, 0};
    v[4]  = '{0, 16'h0,    0, 0, 1, 16'h0,    0, 1, 1, 0, 16'h0000, 9'd0, 16'h0,    0, 9'd0, 0};
    v[5]  = '{0, 16'h0,    1, 1, 1, 16'h0,    0, 1, 1, 0, 16'h0,    9'd0, 16'h0,    0, 9'd0, 0};
    v[6]  = '{0, 16'h0,    1, 1, 0, 16'h1234, 0, 1, 1, 0, 16'h0,    9'd1, 16'h1234, 0, 9'd0, 0};
    v[7]  = '{0, 16'h0,    1, 1, 0, 16'h5678, 0, 1, 1, 0, 16'h0,    9'd2, 16'h1234, 0, 9'd0, 0};
    v[8]  = '{0, 16'h0,    1, 1, 1, 16'h0,    0, 1, 1, 0, 16'h0,    9'd2, 16'h1234, 1, 9'd2, 0};
    v[9]  = '{0, 16'h0,    1, 1, 1, 16'h0,    0, 1, 1, 0, 16'h0,    9'd2, 16'h1234, 0, 9'd2, 0};
    v[10] = '{0, 16'h0,    1, 1, 1, 16'h0,    1, 1, 1, 0, 16'h0,    9'd1, 16'h5678, 0, 9'd2, 0};
    v[11] = '{0, 16'h0,    0, 1, 0, 16'h0,    0, 1, 1, 0, 16'h0000, 9'd1, 16'h5678, 0, 9'd2, 1};
    v[12] = '{0, 16'h0,    1, 1, 1, 16'h0,    0, 1, 1, 0, 16'h0,    9'd1, 16'h5678, 0, 9'd2, 1};
    v[13] = '{0, 16'h0,    1, 1, 1, 16'h0,    1, 1, 1, 0, 16'h0,    9'd0, 16'h0,    0, 9'd2, 1};
    idle_inputs();
    tick();
    tick();
    check_reset_values("reset");
    @(negedge clk);
    rst = 0;
    tick();
    foreach (v[i]) begin
      hv = v[i].hv; hd = v[i].hd; oe_n = v[i].oe_n; rd_n = v[i].rd_n;
      wr_n = v[i].wr_n; wd = v[i].wd; cr = v[i].cr;
      tick();
      chk($sformatf("v%0d ready", i), ifc.host_cmd_ready, v[i].e_rdy);
      chk($sformatf("v%0d rxf_n", i), RXF_N, v[i].e_rxf);
      chk($sformatf("v%0d txe_n", i), TXE_N, v[i].e_txe);
      chk($sformatf("v%0d cap_count", i), ifc.cap_count, v[i].e_cnt);
      chk($sformatf("v%0d cap_data", i), ifc.cap_data, v[i].e_cap);
      chk($sformatf("v%0d done", i), ifc.burst_done, v[i].e_done);
      chk($sformatf("v%0d len", i), ifc.burst_len, v[i].e_len);
      chk($sformatf("v%0d perr", i), ifc.proto_err, v[i].e_perr);
      if (!v[i].oe_n) begin
        chk($sformatf("v%0d data", i), DATA, v[i].e_data);
        chk($sformatf("v%0d be", i), BE, 2'b11);
      end
    end
    idle_inputs();
    tick();
    // 256-word burst fills the capture FIFO, then three dropped words
    dones = 0;
    wr_n = 0;
    for (int i = 0; i < 256; i++) begin
      wd = 16'(i);
      tick();
      dones += int'(ifc.burst_done);
    end
    chk("fill count", ifc.cap_count, 256);
    chk("fill txe_n", TXE_N, 1);
    chk("fill ovf", ifc.overflow, 0);
    for (int i = 0; i < 3; i++) begin
      wd = 16'hDEAD;
      tick();
      dones += int'(ifc.burst_done);
    end
    chk("ovf set", ifc.overflow, 1);
    chk("ovf count", ifc.cap_count, 256);
    chk("no early done", dones, 0);
    wr_n = 1;
    tick();
    chk("fill done", ifc.burst_done, 1);
    chk("fill len", ifc.burst_len, 256);
    tick();
    chk("done one cycle", ifc.burst_done, 0);
    cr = 1;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("drain %0d", i), ifc.cap_data, 16'(i));
      tick();
    end
    cr = 0;
    chk("drain empty", ifc.cap_valid, 0);
    chk("drain txe_n", TXE_N, 0);
    chk("ovf sticky", ifc.overflow, 1);
    // Command FIFO fill, ignored 17th push, simultaneous push and pop at 8
    hv = 1;
    for (int i = 0; i < 16; i++) begin
      hd = 16'(100 + i);
      tick();
    end
    chk("cmd full ready", ifc.host_cmd_ready, 0);
    hd = 16'd999;
    tick();
    hv = 0;
    chk("cmd full still", ifc.host_cmd_ready, 0);
    oe_n = 0;
    tick();
    rd_n = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cmd pop %0d", i), DATA, 16'(100 + i));
      tick();
    end
    chk("cmd head 108", DATA, 16'd108);
    hv = 1;
    hd = 16'd200;
    tick();
    hv = 0;
    n = 0;
    first = DATA;
    last = 16'h0;
    while (!RXF_N && n < 20) begin
      last = DATA;
      n++;
      tick();
    end
    chk("simul count", n, 8);
    chk("simul first", first, 16'd109);
    chk("simul last", last, 16'd200);
    chk("cmd empty data", DATA, 16'h0);
    oe_n = 1;
    rd_n = 1;
    tick();
    // Reset in the middle of a burst
    wr_n = 0;
    for (int i = 0; i < 10; i++) begin
      wd = 16'(i);
      tick();
    end
    chk("mid count", ifc.cap_count, 10);
    #2;
    rst = 1;
    #1;
    check_reset_values("async rst");
    wr_n = 1;
    tick();
    tick();
    chk("rst no done", ifc.burst_done, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("post rst done", ifc.burst_done, 0);
    wr_n = 0;
    for (int i = 0; i < 4; i++) begin
      wd = 16'(i + 40);
      tick();
    end
    wr_n = 1;
    tick();
    chk("burst4 done", ifc.burst_done, 1);
    chk("burst4 len", ifc.burst_len, 4);
    chk("burst4 count", ifc.cap_count, 4);
    // Randomized traffic against the queue model
    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    rst = 0;
    model_reset();
    tick();
    for (int c = 0; c < 3000; c++) begin
      hv = $urandom_range(0, 9) < 4;
      hd = 16'($urandom);
      oe_n = $urandom_range(0, 7) != 0;
      rd_n = $urandom_range(0, 1) == 0;
      if ($urandom_range(0, 9) == 0) wr_n = ~wr_n;
      wd = 16'($urandom);
      cr = $urandom_range(0, 4) == 0;
      model_step();
      tick();
      check_all(c);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_fifo_responder.md
# usb_fifo_responder

Synthesizable device-side model of the 16-bit synchronous FT600-style FIFO bus. It sits opposite the FPGA USB controller, on the same bus, for on-chip loopback and bench use. Host-side logic queues command words that the controller reads via RXF_N/OE_N/RD_N. Data bursts the controller writes via TXE_N/WR_N are captured into a FIFO, with a burst-length report at the end of each burst.

## Interface
- DEPTH_CMD, 16: command FIFO depth in words; power of 2, ≥2.
- DEPTH_CAP, 256: capture FIFO depth in words; power of 2, ≥2. Holds one full y+x frame.
- clk  in  1  single clock for all logic; also serves as the bus CLK fed to the controller.
- reset  in  1  asynchronous, active-high; clears all state.
- host_cmd_data  in  16  command word to queue.
- host_cmd_valid  in  1  push request.
- host_cmd_ready  out  1  high when the command FIFO is not full.
- cap_data  out  16  head of the capture FIFO; 16'h0000 when empty.
- cap_valid  out  1  capture FIFO is non-empty.
- cap_ready  in  1  pop request; acts only when cap_valid is high.
- cap_count  out  $clog2(DEPTH_CAP)+1  words held in the capture FIFO.
- burst_done  out  1  one-cycle pulse at the end of a write burst.
- burst_len  out  9  accepted words in the last burst; held until the next burst_done.
- overflow  out  1  sticky: a write arrived while the capture FIFO was full.
- proto_err  out  1  sticky: WR_N and OE_N were both low at a sampling edge.
- RXF_N  out  1  low when the command FIFO is non-empty.
- TXE_N  out  1  low when the capture FIFO is not full.
- OE_N, RD_N, WR_N  in  1  bus strobes from the controller, active-low.
- DATA  inout  16  bidirectional bus data.
- BE  inout  2  byte enables.

## Operation
- Both FIFOs are first-word-fall-through.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - Counts are registered and one bit wider than the pointers.
- The bus state machine (BUS_IDLE, BUS_READ, BUS_WRITE) is evaluated on each posedge clk.
  - BUS_IDLE → BUS_READ when OE_N==0.
  - BUS_IDLE → BUS_WRITE when WR_N==0 and OE_N==1. This transition clears the burst word counter.
  - BUS_READ → BUS_IDLE when OE_N==1.
  - BUS_WRITE → BUS_IDLE when WR_N==1. This transition fires burst_done and loads burst_len from the counter.
- Read path:
  - DATA is driven combinationally with the command FIFO head while OE_N==0; it reads 16'h0000 if the FIFO is empty.
  - BE is driven to 2'b11 while OE_N==0.
  - DATA and BE are high-Z otherwise.
  - A pop occurs at posedge when OE_N==0, RD_N==0 and the FIFO is non-empty.
  - RD_N low with an empty FIFO has no effect.
- Write path: at posedge with WR_N==0 and OE_N==1, DATA is sampled.
  - If the capture FIFO is not full, the word is pushed and the burst counter increments. The counter saturates at 511.
  - If the capture FIFO is full, the word is dropped and overflow is set.
- Protocol error: WR_N==0 and OE_N==0 at the same edge.
  - The write is ignored and proto_err is set.
  - The read pop still proceeds if RD_N==0.
- Simultaneous events:
  - Host push and bus pop on the same edge both take effect; the count is unchanged. A push is still accepted when the FIFO is full only if host_cmd_ready was high, i.e. never.
  - Bus push and cap pop on the same edge both take effect.
  - TXE_N is computed from the pre-edge count, so a full FIFO blocks the push even when a pop occurs in the same cycle.
- Reset values:
  - Both FIFOs are emptied.
  - host_cmd_ready=1, RXF_N=1, TXE_N=0.
  - cap_valid=0, cap_data=0, cap_count=0.
  - burst_done=0, burst_len=0, overflow=0, proto_err=0.
  - DATA and BE are high-Z.
  - The state machine returns to BUS_IDLE.
  - Reset during a burst aborts it with no burst_done.
- The sticky flags clear only on reset.

## Timing
- Host push at edge N: RXF_N falls after edge N, and the word is visible on DATA from that point while OE_N is low.
- Bus pop at edge N: the next head appears on DATA after edge N. RXF_N rises after edge N if the FIFO is now empty.
- Bus push at edge N: cap_valid rises after edge N, and cap_count updates after edge N. TXE_N rises after edge N when the count reaches DEPTH_CAP.
- burst_done is high for exactly the one cycle following the edge that samples WR_N==1 after a burst.
- Bus timing is zero-latency with no wait states: every edge with the strobes asserted transfers one word.

## Test plan
- Reset released; push 16'hA5A5 and 16'h0001 on the host side; controller reads with OE_N then RD_N low for 2 edges → DATA shows A5A5 then 0001; RXF_N=1 after the second pop.
- WR_N held low for 256 edges carrying 0..255 → cap_count=256 and TXE_N=1; burst_done pulses once with burst_len=256; draining gives 0..255 in order.
- Capture FIFO full while WR_N stays low 3 more edges → overflow=1; cap_count remains 256; burst_len=256.
- Fill the command FIFO to 16 → host_cmd_ready=0 and a 17th push is ignored; a simultaneous host push and bus pop at count 8 → count stays 8.
- WR_N and OE_N both low for one edge → proto_err=1 and cap_count unchanged.
- Reset asserted mid-burst after 10 words → all outputs return to reset values and no burst_done is seen; a subsequent 4-word burst gives burst_len=4.
